mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the byte-enabled data memory: converts CPU load/store requests (byte/half/word, signed/unsigned) into word address, byte write enables and lane-replicated write data.
- Aligns and extends read data returned by the memory.
- Sits between the execute stage and the data memory.
- Request/response valid-ready handshake, one outstanding access.
- Misaligned or out-of-range accesses are flagged and never reach memory.

Parameters:
ADDR_W, 5, word-address width of the memory port; byte space is 2^(ADDR_W+2) bytes (default 128 B)

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_wr  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  aligned/extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size or out-of-range
dm_wen  output  4  byte write enables to memory
dm_addr  output  ADDR_W  word address to memory
dm_wdata  output  32  write data to memory
dm_rdata  input  32  asynchronous read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, resetn=0): state=IDLE; all request registers cleared. Outputs: req_ready=1 (follows IDLE), resp_valid=0, resp_err=0, resp_rdata=0, dm_wen=0, dm_addr=0, dm_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch wr, size, unsigned, addr, wdata.
  - Error check on the latched request: size==3; half with addr[0]!=0; word with addr[1:0]!=0; any addr[31:ADDR_W+2]!=0.
  - No error -> ACCESS. Error -> RESP with resp_err=1, resp_rdata=0; memory untouched.
- ACCESS (exactly one cycle):
  - dm_addr = addr_q[ADDR_W+1:2].
  - Store: dm_wen asserted for this cycle only, so the memory commits on the edge leaving ACCESS.
    - byte: dm_wen = 4'b0001 << addr_q[1:0]; dm_wdata = 4 copies of wdata_q[7:0].
    - half: dm_wen = addr_q[1] ? 4'b1100 : 4'b0011; dm_wdata = 2 copies of wdata_q[15:0].
    - word: dm_wen = 4'b1111; dm_wdata = wdata_q.
  - Load: dm_wen=0. On the exiting edge, capture dm_rdata shifted right by 8*addr_q[1:0], then extend:
    - byte from bit 7; half from bit 15.
    - Zero-extend if unsigned_q, else sign-extend; word passes through unchanged.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready=1.
  - Handshake cycle -> IDLE; resp_valid drops on the next edge.
  - req_ready=0, so no new request can be accepted before IDLE.
- dm_wen is 0 in every state other than ACCESS-with-store.
- dm_addr and dm_wdata are registered and hold their last value outside ACCESS.
- Throughput:
  - 3 cycles per access when resp_ready is tied high.
  - Error path takes 2 cycles (IDLE -> RESP -> IDLE).
- req_valid while not in IDLE is ignored; the requester must hold it.
- resp_ready while resp_valid=0 is ignored.
- Reset asserted during ACCESS:
  - dm_wen drops immediately (asynchronous).
  - A store may or may not have committed, depending on the edge relation; no response is produced.
- req_unsigned is ignored for stores and for word loads.

Test Plan:
- Reset, then sw addr=0x0C data=0xDEADBEEF -> in ACCESS, dm_addr=3 and dm_wen=1111; resp_valid one cycle later with resp_err=0 and resp_rdata=0.
- sb addr=0x0D data=0x000000A5, then lw 0x0C -> dm_wen=0010, dm_wdata=0xA5A5A5A5; lw returns 0xDEADA5EF.
- lb 0x0D -> 0xFFFFFFA5. lbu 0x0D -> 0x000000A5. lh 0x0E -> 0xFFFFDEAD. lhu 0x0E -> 0x0000DEAD.
- Error cases, each -> resp_err=1 after 2 cycles, dm_wen stays 0, and a following lw 0x04 confirms memory is unchanged:
  - sh addr=0x05
  - lw addr=0x06
  - size=3
  - sw addr=0x80
- Hold resp_ready=0 for 5 cycles while req_valid stays high -> resp_valid and resp_rdata stable, req_ready=0; the next request is accepted only after the handshake.
- Deassert resetn mid-ACCESS of sw -> dm_wen=0 in the same cycle, resp_valid=0, req_ready=1 after reset release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-enabled data memory.
// Accepts one CPU request at a time and turns it into a word address, byte
// write enables and lane-replicated write data. Load data coming back from
// the memory is aligned and then sign- or zero-extended. A misaligned,
// illegal-size or out-of-range request is answered with an error and never
// touches the memory.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        dm_wen,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic                r_wr;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [1:0]          r_boff;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;
  logic [3:0]          r_dm_wen;
  logic [ADDR_W-1:0]   r_dm_addr;
  logic [31:0]         r_dm_wdata;

  logic                w_err;
  logic [3:0]          w_wen;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shift;
  logic [31:0]         w_ldata;

  // Classify the incoming request and pre-compute the store lane pattern so
  // the memory-side registers are already correct during ACCESS.
  always_comb begin
    w_err   = |req_addr[31:ADDR_W+2];
    w_wen   = 4'b0000;
    w_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        w_wen   = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_err   = w_err | req_addr[0];
        w_wen   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        w_err   = w_err | (|req_addr[1:0]);
        w_wen   = 4'b1111;
      end
      default: w_err = 1'b1;
    endcase
    if (!req_wr) w_wen = 4'b0000;
  end

  // Right-justify the addressed lane of the read word and extend it.
  always_comb begin
    w_shift = dm_rdata >> {r_boff, 3'b000};
    case (r_size)
      2'd0:    w_ldata = r_unsigned ? {24'd0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ldata = r_unsigned ? {16'd0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ldata = dm_rdata;
    endcase
  end

  // Request FSM; every output is a register so dm_wen is glitch-free and
  // drops asynchronously when reset hits mid-access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_boff       <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_dm_wen     <= 4'b0000;
      r_dm_addr    <= '0;
      r_dm_wdata   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wr        <= req_wr;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_boff      <= req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state   <= ACCESS;
              r_dm_addr <= req_addr[ADDR_W+1:2];
              r_dm_wen  <= w_wen;
              if (req_wr) r_dm_wdata <= w_wdata;
            end
          end
        end
        ACCESS: begin
          // Memory commits the store on this edge; loads sample dm_rdata here.
          r_dm_wen     <= 4'b0000;
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_wr ? 32'd0 : w_ldata;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign dm_wen     = r_dm_wen;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;

endmodule
